// File: rtl/dtw_path_tracer.sv
// DTW traceback engine: walks the direction memory from (len_x-1,len_y-1) down to (0,0), streaming each cell.
// Optional macro DTW_TRACE_CHECK_EN: treat direction code 11 as corrupt and abort the trace with an error pulse.
module dtw_path_tracer #(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] len_x,
   input  logic [IDX_W-1:0] len_y,
   output logic             mem_rd_en,
   output logic [IDX_W-1:0] mem_rd_i,
   output logic [IDX_W-1:0] mem_rd_j,
   input  logic [1:0]       mem_rd_data,
   output logic             path_valid,
   input  logic             path_ready,
   output logic [IDX_W-1:0] path_i,
   output logic [IDX_W-1:0] path_j,
   output logic             path_last,
   output logic             busy,
   output logic             done,
   output logic             error
);

   // state  | meaning
   // IDLE   | waiting for start
   // EMIT   | presenting cell (i,j) on the path port
   // READ   | direction-memory request for (i,j)
   // WAIT   | read data arrives, step to predecessor
   // FIN    | done pulse, then back to IDLE
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_EMIT = 3'd1;
   localparam logic [2:0] S_READ = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]       state;
   logic [IDX_W-1:0] i;
   logic [IDX_W-1:0] j;
   logic             err_q;
   logic             i_zero;
   logic             j_zero;

   assign i_zero = (i == '0);
   assign j_zero = (j == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         i     <= '0;
         j     <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (len_x != '0 && len_y != '0) begin
                     i     <= len_x - 1'b1;
                     j     <= len_y - 1'b1;
                     state <= S_EMIT;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (path_ready) begin
                  if (i_zero && j_zero) begin
                     state <= S_FIN;
                  end else if (i_zero) begin
                     j <= j - 1'b1;
                  end else if (j_zero) begin
                     i <= i - 1'b1;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: state <= S_WAIT;
            S_WAIT: begin
               state <= S_EMIT;
               case (mem_rd_data)
                  2'b00: i <= i - 1'b1;
                  2'b10: j <= j - 1'b1;
                  2'b01: begin
                     i <= i - 1'b1;
                     j <= j - 1'b1;
                  end
                  2'b11: begin
`ifdef DTW_TRACE_CHECK_EN
                     err_q <= 1'b1;
                     state <= S_IDLE;
`else
                     i <= i - 1'b1;
                     j <= j - 1'b1;
`endif
                  end
               endcase
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign path_valid = (state == S_EMIT);
   assign path_last  = path_valid && i_zero && j_zero;
   assign path_i     = i;
   assign path_j     = j;
   // The read address is only meaningful while mem_rd_en is high.
   assign mem_rd_en  = (state == S_READ);
   assign mem_rd_i   = i;
   assign mem_rd_j   = j;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_FIN);
   assign error      = err_q;

endmodule

// File: tb/tb_dtw_path_tracer.sv
// Self-checking bench for dtw_path_tracer: directed corner cases plus randomized traces against a path model.
module tb_dtw_path_tracer;
   logic       clk = 1'b0;
   logic       rst, start, path_ready;
   logic [7:0] len_x, len_y;
   logic       mem_rd_en, path_valid, path_last, busy, done, error;
   logic [7:0] mem_rd_i, mem_rd_j, path_i, path_j;
   logic [1:0] mem_rd_data;

   int tests = 0, fails = 0;
   int cyc = 0;

   dtw_path_tracer #(.IDX_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .len_x(len_x), .len_y(len_y),
      .mem_rd_en(mem_rd_en), .mem_rd_i(mem_rd_i), .mem_rd_j(mem_rd_j),
      .mem_rd_data(mem_rd_data), .path_valid(path_valid), .path_ready(path_ready),
      .path_i(path_i), .path_j(path_j), .path_last(path_last),
      .busy(busy), .done(done), .error(error));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Direction memory with one-cycle read latency; junk on the bus when not reading.
   logic [1:0] mem [0:15][0:15];
   always @(posedge clk)
      mem_rd_data <= mem_rd_en ? mem[mem_rd_i[3:0]][mem_rd_j[3:0]] : 2'($urandom);

   // Observation of the DUT, sampled mid-cycle.
   int q_i[$], q_j[$], q_last[$], q_hs[$], q_rise[$];
   int rd_cnt, rd_bad, done_cnt, done_cyc, err_cnt, err_cyc, start_cyc;
   bit open;

   always @(negedge clk) begin
      if (!rst) begin
         if (start && !busy) start_cyc = cyc;
         if (path_valid && !open) begin
            q_rise.push_back(cyc);
            open = 1'b1;
         end
         if (path_valid && path_ready) begin
            q_i.push_back(int'(path_i));
            q_j.push_back(int'(path_j));
            q_last.push_back(int'(path_last));
            q_hs.push_back(cyc);
            open = 1'b0;
         end
         if (mem_rd_en) begin
            rd_cnt++;
            if (q_i.size() == 0 || int'(mem_rd_i) != q_i[$] || int'(mem_rd_j) != q_j[$]) rd_bad++;
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (error) begin err_cnt++; err_cyc = cyc; end
      end
   end

   task automatic clear_obs();
      q_i.delete(); q_j.delete(); q_last.delete(); q_hs.delete(); q_rise.delete();
      rd_cnt = 0; rd_bad = 0; done_cnt = 0; err_cnt = 0; open = 1'b0;
      done_cyc = -1; err_cyc = -1; start_cyc = -1;
   endtask

   task automatic fill_mem(input int code, input bit rnd);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            mem[a][b] = rnd ? 2'($urandom_range(2)) : 2'(code);
   endtask

   // Reference: walk the matrix by the decoding rules, recording every visited cell.
   int exp_i[$], exp_j[$];
   int exp_reads;
   bit exp_err;
   task automatic compute_expected(input int lx, input int ly);
      int ci, cj;
      exp_i.delete(); exp_j.delete(); exp_reads = 0; exp_err = 1'b0;
      ci = lx - 1; cj = ly - 1;
      forever begin
         exp_i.push_back(ci); exp_j.push_back(cj);
         if (ci == 0 && cj == 0) break;
         if (ci == 0) cj--;
         else if (cj == 0) ci--;
         else begin
            exp_reads++;
            case (mem[ci][cj])
               2'd0: ci--;
               2'd2: cj--;
               2'd1: begin ci--; cj--; end
               default: begin
`ifdef DTW_TRACE_CHECK_EN
                  exp_err = 1'b1;
                  break;
`else
                  ci--; cj--;
`endif
               end
            endcase
         end
      end
   endtask

   task automatic run_trace(input int lx, input int ly, input int pct, output bit timeout);
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; len_x = 8'(lx); len_y = 8'(ly);
      path_ready = ($urandom_range(99) < pct);
      @(posedge clk); #1;
      start = 1'b0;
      timeout = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (done_cnt != 0 || err_cnt != 0) begin timeout = 1'b0; break; end
         @(posedge clk); #1;
         path_ready = ($urandom_range(99) < pct);
      end
      path_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len_x = 0; len_y = 0; path_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({mem_rd_en, path_valid, path_last, busy, done, error} !== 6'b0) begin
         $display("FAIL reset_flags got %b want 000000", {mem_rd_en, path_valid, path_last, busy, done, error});
         fails++;
      end
      tests++;
      if ({path_i, path_j, mem_rd_i, mem_rd_j} !== 32'h0) begin
         $display("FAIL reset_coords got %h want 0", {path_i, path_j, mem_rd_i, mem_rd_j});
         fails++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      bit to;
      run_trace(1, 1, 100, to);
      tests++;
      if (to || q_i.size() !== 1 || q_i[0] !== 0 || q_j[0] !== 0 || q_last[0] !== 1) begin
         $display("FAIL single_beat got n=%0d to=%0d want one beat (0,0) last=1", q_i.size(), to);
         fails++;
      end else begin
         tests++;
         if (rd_cnt !== 0 || done_cnt !== 1 || done_cyc - q_hs[0] !== 1 || q_rise[0] - start_cyc !== 1) begin
            $display("FAIL single_timing got rd=%0d done=%0d dlat=%0d vlat=%0d want 0 1 1 1",
                     rd_cnt, done_cnt, done_cyc - q_hs[0], q_rise[0] - start_cyc);
            fails++;
         end
      end
   endtask

   task automatic test_diag3();
      bit to;
      fill_mem(1, 1'b0);
      run_trace(3, 3, 100, to);
      tests++;
      if (to || q_i.size() !== 3 || q_i[0] !== 2 || q_j[0] !== 2 || q_i[1] !== 1 || q_j[1] !== 1
          || q_i[2] !== 0 || q_j[2] !== 0 || q_last[2] !== 1 || q_last[1] !== 0) begin
         $display("FAIL diag3_beats got n=%0d to=%0d want (2,2)(1,1)(0,0)", q_i.size(), to);
         fails++;
      end else begin
         tests++;
         if (rd_cnt !== 2 || rd_bad !== 0 || q_rise[1] - q_hs[0] !== 3 || q_rise[2] - q_hs[1] !== 3) begin
            $display("FAIL diag3_timing got rd=%0d bad=%0d gaps=%0d,%0d want 2 0 3,3",
                     rd_cnt, rd_bad, q_rise[1] - q_hs[0], q_rise[2] - q_hs[1]);
            fails++;
         end
      end
   endtask

   task automatic test_edge();
      bit to;
      run_trace(3, 1, 100, to);
      tests++;
      if (to || q_i.size() !== 3 || q_i[0] !== 2 || q_i[1] !== 1 || q_i[2] !== 0
          || q_j[0] !== 0 || q_j[1] !== 0 || q_j[2] !== 0) begin
         $display("FAIL edge_beats got n=%0d to=%0d want (2,0)(1,0)(0,0)", q_i.size(), to);
         fails++;
      end else begin
         tests++;
         if (rd_cnt !== 0 || q_rise[1] - q_hs[0] !== 1 || q_rise[2] - q_hs[1] !== 1) begin
            $display("FAIL edge_timing got rd=%0d gaps=%0d,%0d want 0 1,1",
                     rd_cnt, q_rise[1] - q_hs[0], q_rise[2] - q_hs[1]);
            fails++;
         end
      end
   endtask

   task automatic test_codes();
      bit to;
      fill_mem(1, 1'b0);
      mem[2][2] = 2'b00;
      mem[1][2] = 2'b10;
      run_trace(3, 3, 100, to);
      tests++;
      if (to || q_i.size() !== 4 || q_i[0] !== 2 || q_j[0] !== 2 || q_i[1] !== 1 || q_j[1] !== 2
          || q_i[2] !== 1 || q_j[2] !== 1 || q_i[3] !== 0 || q_j[3] !== 0) begin
         $display("FAIL codes_beats got n=%0d to=%0d want (2,2)(1,2)(1,1)(0,0)", q_i.size(), to);
         fails++;
      end
   endtask

   task automatic test_backpressure();
      bit fin;
      fill_mem(1, 1'b0);
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; len_x = 3; len_y = 3; path_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests++;
         if (path_valid !== 1'b1 || path_i !== 8'd2 || path_j !== 8'd2 || path_last !== 1'b0 || mem_rd_en !== 1'b0) begin
            $display("FAIL hold_cycle%0d got v=%b i=%0d j=%0d last=%b rd=%b want 1 2 2 0 0",
                     k, path_valid, path_i, path_j, path_last, mem_rd_en);
            fails++;
         end
      end
      @(posedge clk); #1;
      path_ready = 1'b1;
      fin = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done_cnt != 0) begin fin = 1'b1; break; end
      end
      tests++;
      if (!fin || q_i.size() !== 3 || rd_cnt !== 2) begin
         $display("FAIL hold_finish got fin=%0d n=%0d rd=%0d want 1 3 2", fin, q_i.size(), rd_cnt);
         fails++;
      end
   endtask

   task automatic test_code11();
      bit to;
      fill_mem(1, 1'b0);
      mem[2][2] = 2'b11;
      run_trace(3, 3, 100, to);
      tests++;
`ifdef DTW_TRACE_CHECK_EN
      if (to || q_i.size() !== 1 || err_cnt !== 1 || done_cnt !== 0 || busy !== 1'b0) begin
         $display("FAIL code11_abort got n=%0d err=%0d done=%0d busy=%b want 1 1 0 0",
                  q_i.size(), err_cnt, done_cnt, busy);
         fails++;
      end
`else
      if (to || q_i.size() !== 3 || q_i[1] !== 1 || q_j[1] !== 1 || err_cnt !== 0 || done_cnt !== 1) begin
         $display("FAIL code11_diag got n=%0d err=%0d done=%0d want 3 beats, (1,1) second, 0 1",
                  q_i.size(), err_cnt, done_cnt);
         fails++;
      end
`endif
   endtask

   task automatic test_zero_len();
      bit to;
      run_trace(0, 3, 100, to);
      tests++;
      if (to || err_cnt !== 1 || err_cyc - start_cyc !== 1 || q_i.size() !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
         $display("FAIL zero_len got to=%0d err=%0d lat=%0d beats=%0d done=%0d busy=%b want 0 1 1 0 0 0",
                  to, err_cnt, err_cyc - start_cyc, q_i.size(), done_cnt, busy);
         fails++;
      end
      run_trace(4, 0, 100, to);
      tests++;
      if (to || err_cnt !== 1 || q_i.size() !== 0 || done_cnt !== 0) begin
         $display("FAIL zero_len_y got err=%0d beats=%0d done=%0d want 1 0 0", err_cnt, q_i.size(), done_cnt);
         fails++;
      end
   endtask

   task automatic test_start_on_done();
      bit stray;
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; len_x = 1; len_y = 1; path_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      // The handshake has just completed; done is high for this cycle.
      start = 1'b1; len_x = 2; len_y = 2;
      @(posedge clk); #1;
      start = 1'b0;
      stray = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy || path_valid) stray = 1'b1;
      end
      tests++;
      if (stray || q_i.size() !== 1 || done_cnt !== 1) begin
         $display("FAIL start_on_done got stray=%0d beats=%0d done=%0d want 0 1 1", stray, q_i.size(), done_cnt);
         fails++;
      end
   endtask

   task automatic test_reset_mid();
      bit seen, to;
      fill_mem(0, 1'b1);
      mem[3][3] = 2'b01;
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; len_x = 4; len_y = 4; path_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (mem_rd_en) begin seen = 1'b1; break; end
      end
      tests++;
      if (!seen) begin
         $display("FAIL rst_mid_read got no mem_rd_en within 50 cycles want a read");
         fails++;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({mem_rd_en, path_valid, path_last, busy, done, error} !== 6'b0
          || {path_i, path_j, mem_rd_i, mem_rd_j} !== 32'h0) begin
         $display("FAIL rst_mid_outputs got flags=%b coords=%h want 0 0",
                  {mem_rd_en, path_valid, path_last, busy, done, error}, {path_i, path_j, mem_rd_i, mem_rd_j});
         fails++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         $display("FAIL rst_mid_nodone got done=%0d busy=%b want 0 0", done_cnt, busy);
         fails++;
      end
      run_trace(1, 1, 100, to);
      tests++;
      if (to || q_i.size() !== 1 || q_last[0] !== 1 || done_cnt !== 1 || rd_cnt !== 0) begin
         $display("FAIL rst_mid_after got n=%0d done=%0d rd=%0d want 1 1 0", q_i.size(), done_cnt, rd_cnt);
         fails++;
      end
   endtask

   task automatic test_random();
      bit to;
      int lx, ly, pct, bad;
      for (int t = 0; t < 40; t++) begin
         lx = $urandom_range(12, 1);
         ly = $urandom_range(12, 1);
         pct = $urandom_range(100, 30);
         fill_mem(0, 1'b1);
         compute_expected(lx, ly);
         run_trace(lx, ly, pct, to);
         tests++;
         if (to || q_i.size() !== exp_i.size()) begin
            $display("FAIL rand%0d_len %0dx%0d got n=%0d to=%0d want %0d", t, lx, ly, q_i.size(), to, exp_i.size());
            fails++;
            continue;
         end
         bad = 0;
         for (int k = 0; k < q_i.size(); k++)
            if (q_i[k] !== exp_i[k] || q_j[k] !== exp_j[k] || q_last[k] !== int'(k == q_i.size() - 1)) bad++;
         tests++;
         if (bad !== 0 || rd_cnt !== exp_reads || rd_bad !== 0 || done_cnt !== 1 || err_cnt !== 0
             || q_i.size() < (lx > ly ? lx : ly) || q_i.size() > lx + ly - 1) begin
            $display("FAIL rand%0d_path %0dx%0d got bad=%0d rd=%0d/%0d rdaddr=%0d done=%0d err=%0d want 0 %0d 0 1 0",
                     t, lx, ly, bad, rd_cnt, exp_reads, rd_bad, done_cnt, err_cnt, exp_reads);
            fails++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_diag3();
      test_edge();
      test_codes();
      test_backpressure();
      test_code11();
      test_zero_len();
      test_start_on_done();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dtw_path_tracer.md
DTW_PATH_TRACER -- requirements
Module: dtw_path_tracer

Interface
REQ-001 SHALL have parameter IDX_W, default 8, which is the cell index width.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a traceback; ignored while busy.
REQ-005 SHALL have ports len_x and len_y, input, IDX_W each: sequence lengths, sampled when start is accepted.
REQ-006 SHALL have ports mem_rd_en (output, 1), mem_rd_i (output, IDX_W) and mem_rd_j (output, IDX_W): the direction-memory read request.
REQ-007 SHALL have port mem_rd_data, input, 2: the stored direction code; valid exactly 1 cycle after mem_rd_en.
REQ-008 SHALL have ports path_valid (output, 1) and path_ready (input, 1): the path-output handshake.
REQ-009 SHALL have ports path_i and path_j (output, IDX_W each) and path_last (output, 1): the current path cell, plus a flag that it is cell (0,0).
REQ-010 SHALL have ports busy, done and error, output, 1 each: busy means the trace is active; done and error are one-cycle pulses.

Function
REQ-011 SHALL decode direction codes as follows: 00 steps to (i-1,j); 01 steps to (i-1,j-1); 10 steps to (i,j-1). This matches the calculator's Number encoding.
REQ-012 SHALL implement the FSM states IDLE, EMIT, READ, WAIT and FIN.
REQ-013 IDLE: on start with len_x!=0 and len_y!=0, SHALL load i=len_x-1 and j=len_y-1, set busy and go to EMIT.
REQ-014 IDLE: on start with len_x==0 or len_y==0, SHALL pulse error the next cycle, emit no beats and stay in IDLE.
REQ-015 EMIT: SHALL assert path_valid with (i,j), and path_last=1 iff i==0 and j==0.
REQ-016 Held beats SHALL keep path_i, path_j and path_last stable until the handshake (path_valid && path_ready) completes.
REQ-017 On handshake at cell (0,0), SHALL go to FIN.
REQ-018 On handshake at a cell with i==0 XOR j==0, SHALL perform a forced move (j-1 or i-1 respectively) with no memory read, and re-enter EMIT.
REQ-019 On handshake at an interior cell, SHALL go to READ.
REQ-020 READ: SHALL assert mem_rd_en for exactly 1 cycle with mem_rd_i=i and mem_rd_j=j, then go to WAIT.
REQ-021 WAIT: SHALL sample mem_rd_data, update (i,j) per REQ-011 and go to EMIT.
REQ-022 Latency: SHALL assert first path_valid 1 cycle after start is accepted.
REQ-023 Latency: for an interior cell, SHALL assert the next path_valid 3 cycles after the handshake.
REQ-024 Latency: for a forced move, SHALL assert the next path_valid 1 cycle after the handshake.
REQ-025 FIN: SHALL pulse done for 1 cycle, clear busy and return to IDLE.
REQ-026 SHALL produce path length between max(len_x,len_y) and len_x+len_y-1 beats; i and j SHALL never underflow.
REQ-027 A start arriving in the same cycle as done SHALL be ignored.

Reset
REQ-028 Reset SHALL force IDLE.
REQ-029 Reset SHALL set mem_rd_en, path_valid, path_last, busy, done and error to 0, and set path_i, path_j, mem_rd_i and mem_rd_j to 0.
REQ-030 Reset asserted mid-trace SHALL abort immediately: no done pulse, and mem_rd_data from an in-flight read is discarded.

Configuration
REQ-031 Macro DTW_TRACE_CHECK_EN SHALL control handling of code 11.
REQ-032 With DTW_TRACE_CHECK_EN defined, code 11 sampled in WAIT SHALL pulse error for 1 cycle, emit no further beats, skip done, clear busy and return to IDLE.
REQ-033 Without DTW_TRACE_CHECK_EN, code 11 SHALL be treated as 01 (diagonal) and error SHALL only pulse per REQ-014.

Verification
REQ-034 len_x=1, len_y=1, start -> one beat (0,0) with path_last=1, no mem_rd_en, done pulses 1 cycle after the handshake.
REQ-035 len 3x3, all codes 01, path_ready=1 -> beats (2,2),(1,1),(0,0); mem_rd_en exactly twice; the gap between beats is 3 cycles.
REQ-036 len_x=3, len_y=1 -> beats (2,0),(1,0),(0,0), zero memory reads, beats on consecutive cycles. Codes 00 at (2,2) and 10 at (1,2) -> beats (2,2),(1,2),(1,1),... .
REQ-037 path_ready held low 5 cycles during beat (2,2) -> path_valid and data stable all 5 cycles, and no mem_rd_en issued.
REQ-038 Code 11 at (2,2): with DTW_TRACE_CHECK_EN -> error pulse, no second beat, done=0. Without the macro -> second beat is (1,1).
REQ-039 rst asserted in WAIT during a 4x4 trace -> next cycle all outputs are 0 and busy=0. A following start with 1x1 gives a clean single beat.
